pair_order_ctrl: RTL and testbench
==================================

PAIR_ORDER_CTRL -- requirements
Module: pair_order_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, cycles waited in WAIT_SECOND before partial flush; 0 = never flush.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  2  per-requester data valid; bit i = requester i.
REQ-005 SHALL have port req_data  input  2  per-requester 1-bit payload.
REQ-006 SHALL have port req_ready  output  2  per-requester grant; transfer i occurs when req_valid[i] and req_ready[i] are both high.
REQ-007 SHALL have port order  input  1  lane mapping, sampled on the first transfer of a pair.
REQ-008 SHALL have port out  output  2  registered paired result.
REQ-009 SHALL have port out_valid  output  1  out holds a complete or partial pair.
REQ-010 SHALL have port out_partial  output  1  the pair was flushed by timeout; the missing lane reads 0.
REQ-011 SHALL have port out_ready  input  1  consumer acceptance.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT_SECOND and OUTPUT.
REQ-013 In IDLE, SHALL assert req_ready only for the arbitration winner among valid requesters, one transfer per cycle, then move to WAIT_SECOND.
REQ-014 In WAIT_SECOND, SHALL assert req_ready only for the requester not yet captured.
REQ-015 SHALL hold req_ready at 00 in OUTPUT; req_ready is combinational from state, req_valid and the priority pointer.
REQ-016 SHALL latch order on the first transfer of a pair; later changes to order are ignored until the next IDLE.
REQ-017 SHALL use lane mapping order=0: requester0 to out[1], requester1 to out[0]; order=1: requester0 to out[0], requester1 to out[1].
REQ-018 On the second transfer, SHALL load out, set out_valid=1 and out_partial=0 on the next edge, and enter OUTPUT; latency from second transfer to out_valid is 1 cycle.
REQ-019 SHALL count cycles in WAIT_SECOND; when the count reaches TIMEOUT with no transfer, SHALL load the captured lane, zero the other lane, set out_partial=1 and enter OUTPUT.
REQ-020 If a transfer and the timeout coincide, the transfer SHALL win (out_partial=0).
REQ-021 SHALL hold out, out_valid and out_partial stable in OUTPUT until out_ready=1; on that edge, out_valid and out_partial clear, out retains its value, and the FSM returns to IDLE.
REQ-022 SHALL NOT capture in the cycle OUTPUT returns to IDLE; a new pair may start the following cycle.
REQ-023 The timeout counter SHALL saturate at TIMEOUT, clear on leaving WAIT_SECOND, and be at least 8 bits wide.

Reset
REQ-024 On reset_n low, SHALL asynchronously force state=IDLE, out=2'b00, out_valid=0, out_partial=0, priority pointer=0, counter=0, latched order=0.
REQ-025 Reset asserted mid-pair or in OUTPUT SHALL discard the pending pair with no output.

Configuration
REQ-026 With PAIR_ORDER_RR_EN defined, SHALL use round-robin arbitration: on simultaneous IDLE requests the pointer-favoured requester wins, and the pointer toggles after every IDLE grant.
REQ-027 Without PAIR_ORDER_RR_EN, SHALL use fixed priority: requester0 always wins a simultaneous request, and the pointer is absent.

Structure
REQ-028 Package pair_order_pkg SHALL hold the state enum, lane index constants (LANE_HI=1, LANE_LO=0) and the default TIMEOUT.
REQ-029 Arbitration SHALL reside in sub-module rr_arb2 (2-way, with pointer input and grant output), compiled for both configurations.

Verification
REQ-030 Verify: req_valid=01, data0=1, order=0; then req_valid=10, data1=0 -> out=2'b10, out_valid=1, out_partial=0 one cycle after the second transfer.
REQ-031 Verify: same as REQ-030 with order=1 at the first transfer and order toggled before the second -> out=2'b01.
REQ-032 Verify: req_valid=11 in IDLE with RR enabled across two pairs -> grants 01 then 10 on the first pair, and 10 first on the second pair; with RR disabled -> 01 first both times.
REQ-033 Verify: TIMEOUT=3, one transfer of data0=1 with order=0 and no second request -> out=2'b10, out_partial=1 after 3 WAIT_SECOND cycles.
REQ-034 Verify: out_ready held 0 for 5 cycles -> out stable, req_ready=00; out_ready=1 -> out_valid=0 next cycle, out unchanged.
REQ-035 Verify: reset_n low in WAIT_SECOND, asynchronously between clock edges -> all outputs 0 immediately; the next pair is processed normally.

Source files
------------

// File: rtl/pair_order_pkg.sv
// Shared types and constants for the pair ordering controller.
// Holds the FSM state enum, the output lane indices, the default flush
// timeout and the helper that places one requester bit into its lane.
package pair_order_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_SECOND = 2'd1,
      OUTPUT      = 2'd2
   } pairState_e;

   localparam int unsigned LANE_HI = 1;
   localparam int unsigned LANE_LO = 0;

   localparam int DEFAULT_TIMEOUT = 15;

   // Returns a 2-bit word holding dataBit in the lane that reqIdx maps to
   // under orderBit, with the other lane zero. order=0 swaps requesters
   // onto lanes (req0 -> hi), order=1 keeps them straight (req0 -> lo).
   function automatic logic [1:0] placeBit(input logic reqIdx,
                                           input logic orderBit,
                                           input logic dataBit);
      logic [1:0] lanes;
      lanes = 2'b00;
      if (reqIdx == orderBit) begin
         lanes[LANE_HI] = dataBit;
      end else begin
         lanes[LANE_LO] = dataBit;
      end
      return lanes;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter. A lone request is granted directly; on a simultaneous
// request the pointer picks the winner (0 -> requester0, 1 -> requester1).
// Tying the pointer low turns it into a fixed-priority arbiter.
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       ptr_i,
   output logic [1:0] grant_o
);

   // Grant the single requester, or the pointer-favoured one on a tie.
   always_comb begin
      grant_o = req_i;
      if (req_i == 2'b11) begin
         grant_o = ptr_i ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/pair_order_ctrl.sv
// Collects one bit from each of two requesters, maps them onto output lanes
// according to the order sampled on the first transfer, and presents the
// pair until the consumer accepts it. A pair left half-filled for TIMEOUT
// cycles is flushed as a partial result (TIMEOUT = 0 disables the flush).
// Define PAIR_ORDER_RR_EN for round-robin arbitration in IDLE; the default
// build uses fixed priority with requester0 winning ties.
module pair_order_ctrl
   import pair_order_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req_valid,
   input  logic [1:0] req_data,
   output logic [1:0] req_ready,
   input  logic       order,
   output logic [1:0] out,
   output logic       out_valid,
   output logic       out_partial,
   input  logic       out_ready
);

   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT);
   localparam bit TIMEOUT_EN = (TIMEOUT != 0);

   pairState_e       state_q, state_d;
   logic [1:0]       hold_q, hold_d;
   logic             capIdx_q, capIdx_d;
   logic             order_q, order_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cntInc;
   logic             timeoutHit;
   logic [1:0]       out_q, out_d;
   logic             outValid_q, outValid_d;
   logic             outPartial_q, outPartial_d;
   logic [1:0]       grant;
   logic [1:0]       xfer;
   logic             xferIdx;
   logic             arbPtr;

`ifdef PAIR_ORDER_RR_EN
   logic ptr_q, ptr_d;
   assign arbPtr = ptr_q;
`else
   assign arbPtr = 1'b0;
`endif

   rr_arb2 u_arb (
      .req_i   (req_valid),
      .ptr_i   (arbPtr),
      .grant_o (grant)
   );

   // Ready goes to the arbitration winner in IDLE, to the missing requester
   // while waiting for the second half, and nowhere while the result is held.
   always_comb begin
      req_ready = 2'b00;
      case (state_q)
         IDLE:        req_ready = grant;
         WAIT_SECOND: req_ready = capIdx_q ? 2'b01 : 2'b10;
         default:     req_ready = 2'b00;
      endcase
   end

   assign xfer    = req_valid & req_ready;
   assign xferIdx = xfer[1];

   assign cntInc     = (cnt_q < TIMEOUT_LIM) ? cnt_q + CNT_W'(1) : cnt_q;
   assign timeoutHit = TIMEOUT_EN && (cntInc == TIMEOUT_LIM);

   // Next-state logic: capture the first half, complete or flush the pair,
   // then hold it until the consumer takes it. A transfer beats the timeout.
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      capIdx_d     = capIdx_q;
      order_d      = order_q;
      cnt_d        = cnt_q;
      out_d        = out_q;
      outValid_d   = outValid_q;
      outPartial_d = outPartial_q;
`ifdef PAIR_ORDER_RR_EN
      ptr_d        = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (|xfer) begin
               order_d  = order;
               capIdx_d = xferIdx;
               hold_d   = placeBit(xferIdx, order, req_data[xferIdx]);
               cnt_d    = '0;
               state_d  = WAIT_SECOND;
`ifdef PAIR_ORDER_RR_EN
               ptr_d    = ~ptr_q;
`endif
            end
         end
         WAIT_SECOND: begin
            if (|xfer) begin
               out_d        = hold_q | placeBit(xferIdx, order_q, req_data[xferIdx]);
               outValid_d   = 1'b1;
               outPartial_d = 1'b0;
               cnt_d        = '0;
               state_d      = OUTPUT;
            end else if (timeoutHit) begin
               out_d        = hold_q;
               outValid_d   = 1'b1;
               outPartial_d = 1'b1;
               cnt_d        = '0;
               state_d      = OUTPUT;
            end else begin
               cnt_d = cntInc;
            end
         end
         OUTPUT: begin
            if (out_ready) begin
               outValid_d   = 1'b0;
               outPartial_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset drops any pending pair.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         hold_q       <= 2'b00;
         capIdx_q     <= 1'b0;
         order_q      <= 1'b0;
         cnt_q        <= '0;
         out_q        <= 2'b00;
         outValid_q   <= 1'b0;
         outPartial_q <= 1'b0;
`ifdef PAIR_ORDER_RR_EN
         ptr_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         capIdx_q     <= capIdx_d;
         order_q      <= order_d;
         cnt_q        <= cnt_d;
         out_q        <= out_d;
         outValid_q   <= outValid_d;
         outPartial_q <= outPartial_d;
`ifdef PAIR_ORDER_RR_EN
         ptr_q        <= ptr_d;
`endif
      end
   end

   assign out         = out_q;
   assign out_valid   = outValid_q;
   assign out_partial = outPartial_q;

endmodule

// File: tb/tb_pair_order_ctrl.sv
// Directed bench for pair_order_ctrl built with TIMEOUT=3. Inputs change on
// the falling edge; req_ready is sampled 1 unit later and registered outputs
// 1 unit after the rising edge. Expectations follow PAIR_ORDER_RR_EN.
module tb_pair_order_ctrl;

   logic       clk;
   logic       reset_n;
   logic [1:0] req_valid;
   logic [1:0] req_data;
   logic [1:0] req_ready;
   logic       order;
   logic [1:0] out;
   logic       out_valid;
   logic       out_partial;
   logic       out_ready;

   int vecCount  = 0;
   int missCount = 0;

   pair_order_ctrl #(.TIMEOUT(3)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .order       (order),
      .out         (out),
      .out_valid   (out_valid),
      .out_partial (out_partial),
      .out_ready   (out_ready)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle's inputs on the falling edge and settle.
   task automatic applyStimulus(input logic [1:0] v, input logic [1:0] d,
                                input logic o, input logic r);
      @(negedge clk);
      req_valid = v;
      req_data  = d;
      order     = o;
      out_ready = r;
      #1;
   endtask

   // Advance past the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; req_valid = 2'b00; req_data = 2'b00; order = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vecCount++; if (out !== 2'b00) begin missCount++; $display("[TB] FAIL reset_out: got %b want 00", out); end
      vecCount++; if (out_valid !== 1'b0) begin missCount++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
      vecCount++; if (out_partial !== 1'b0) begin missCount++; $display("[TB] FAIL reset_partial: got %b want 0", out_partial); end
      vecCount++; if (req_ready !== 2'b00) begin missCount++; $display("[TB] FAIL reset_ready: got %b want 00", req_ready); end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_order0();
      applyStimulus(2'b01, 2'b01, 1'b0, 1'b0);
      vecCount++; if (req_ready !== 2'b01) begin missCount++; $display("[TB] FAIL o0_ready_first: got %b want 01", req_ready); end
      tick();
      vecCount++; if (out_valid !== 1'b0) begin missCount++; $display("[TB] FAIL o0_valid_wait: got %b want 0", out_valid); end
      applyStimulus(2'b10, 2'b00, 1'b0, 1'b0);
      vecCount++; if (req_ready !== 2'b10) begin missCount++; $display("[TB] FAIL o0_ready_second: got %b want 10", req_ready); end
      tick();
      vecCount++; if (out !== 2'b10) begin missCount++; $display("[TB] FAIL o0_out: got %b want 10", out); end
      vecCount++; if (out_valid !== 1'b1) begin missCount++; $display("[TB] FAIL o0_valid: got %b want 1", out_valid); end
      vecCount++; if (out_partial !== 1'b0) begin missCount++; $display("[TB] FAIL o0_partial: got %b want 0", out_partial); end
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
      tick();
      vecCount++; if (out_valid !== 1'b0) begin missCount++; $display("[TB] FAIL o0_valid_clr: got %b want 0", out_valid); end
      vecCount++; if (out !== 2'b10) begin missCount++; $display("[TB] FAIL o0_out_kept: got %b want 10", out); end
   endtask

   task automatic test_order1();
      applyStimulus(2'b01, 2'b01, 1'b1, 1'b0);
      tick();
      applyStimulus(2'b10, 2'b00, 1'b0, 1'b0);
      tick();
      vecCount++; if (out !== 2'b01) begin missCount++; $display("[TB] FAIL o1_out: got %b want 01", out); end
      vecCount++; if (out_valid !== 1'b1) begin missCount++; $display("[TB] FAIL o1_valid: got %b want 1", out_valid); end
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
      tick();
   endtask

   task automatic test_arbitration();
      logic [1:0] first2;
      logic [1:0] second2;
`ifdef PAIR_ORDER_RR_EN
      first2 = 2'b10; second2 = 2'b01;
`else
      first2 = 2'b01; second2 = 2'b10;
`endif
      applyStimulus(2'b11, 2'b10, 1'b0, 1'b0);
      vecCount++; if (req_ready !== 2'b01) begin missCount++; $display("[TB] FAIL arb_p1_first: got %b want 01", req_ready); end
      tick();
      applyStimulus(2'b11, 2'b10, 1'b0, 1'b0);
      vecCount++; if (req_ready !== 2'b10) begin missCount++; $display("[TB] FAIL arb_p1_second: got %b want 10", req_ready); end
      tick();
      vecCount++; if (out !== 2'b01) begin missCount++; $display("[TB] FAIL arb_p1_out: got %b want 01", out); end
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
      tick();
      applyStimulus(2'b11, 2'b01, 1'b1, 1'b0);
      vecCount++; if (req_ready !== first2) begin missCount++; $display("[TB] FAIL arb_p2_first: got %b want %b", req_ready, first2); end
      tick();
      applyStimulus(2'b11, 2'b01, 1'b1, 1'b0);
      vecCount++; if (req_ready !== second2) begin missCount++; $display("[TB] FAIL arb_p2_second: got %b want %b", req_ready, second2); end
      tick();
      vecCount++; if (out !== 2'b01) begin missCount++; $display("[TB] FAIL arb_p2_out: got %b want 01", out); end
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
      tick();
   endtask

   task automatic test_hold();
      applyStimulus(2'b01, 2'b01, 1'b0, 1'b0);
      tick();
      applyStimulus(2'b10, 2'b10, 1'b0, 1'b0);
      tick();
      vecCount++; if (out !== 2'b11) begin missCount++; $display("[TB] FAIL hold_out: got %b want 11", out); end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(2'b11, 2'b00, 1'b1, 1'b0);
         vecCount++; if (req_ready !== 2'b00) begin missCount++; $display("[TB] FAIL hold_ready[%0d]: got %b want 00", i, req_ready); end
         vecCount++; if (out !== 2'b11 || out_valid !== 1'b1) begin missCount++; $display("[TB] FAIL hold_stable[%0d]: got out=%b valid=%b want out=11 valid=1", i, out, out_valid); end
         tick();
      end
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
      tick();
      vecCount++; if (out_valid !== 1'b0) begin missCount++; $display("[TB] FAIL hold_valid_clr: got %b want 0", out_valid); end
      vecCount++; if (out !== 2'b11) begin missCount++; $display("[TB] FAIL hold_out_kept: got %b want 11", out); end
   endtask

   task automatic test_timeout();
      applyStimulus(2'b01, 2'b01, 1'b0, 1'b0);
      tick();
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
      vecCount++; if (req_ready !== 2'b10) begin missCount++; $display("[TB] FAIL to_ready_wait: got %b want 10", req_ready); end
      tick();
      vecCount++; if (out_valid !== 1'b0) begin missCount++; $display("[TB] FAIL to_early1: got %b want 0", out_valid); end
      tick();
      vecCount++; if (out_valid !== 1'b0) begin missCount++; $display("[TB] FAIL to_early2: got %b want 0", out_valid); end
      tick();
      vecCount++; if (out !== 2'b10) begin missCount++; $display("[TB] FAIL to_out: got %b want 10", out); end
      vecCount++; if (out_valid !== 1'b1) begin missCount++; $display("[TB] FAIL to_valid: got %b want 1", out_valid); end
      vecCount++; if (out_partial !== 1'b1) begin missCount++; $display("[TB] FAIL to_partial: got %b want 1", out_partial); end
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
      tick();
      vecCount++; if (out_valid !== 1'b0 || out_partial !== 1'b0) begin missCount++; $display("[TB] FAIL to_clr: got valid=%b partial=%b want 0 0", out_valid, out_partial); end
      vecCount++; if (out !== 2'b10) begin missCount++; $display("[TB] FAIL to_out_kept: got %b want 10", out); end
   endtask

   task automatic test_timeout_race();
      applyStimulus(2'b01, 2'b01, 1'b0, 1'b0);
      tick();
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
      tick();
      tick();
      applyStimulus(2'b10, 2'b10, 1'b0, 1'b0);
      tick();
      vecCount++; if (out !== 2'b11) begin missCount++; $display("[TB] FAIL race_out: got %b want 11", out); end
      vecCount++; if (out_partial !== 1'b0) begin missCount++; $display("[TB] FAIL race_partial: got %b want 0", out_partial); end
      vecCount++; if (out_valid !== 1'b1) begin missCount++; $display("[TB] FAIL race_valid: got %b want 1", out_valid); end
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
      tick();
   endtask

   task automatic test_async_reset();
      applyStimulus(2'b01, 2'b01, 1'b0, 1'b0);
      tick();
      @(negedge clk);
      req_valid = 2'b00;
      out_ready = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      vecCount++; if (out !== 2'b00) begin missCount++; $display("[TB] FAIL ar_out: got %b want 00", out); end
      vecCount++; if (out_valid !== 1'b0 || out_partial !== 1'b0) begin missCount++; $display("[TB] FAIL ar_flags: got valid=%b partial=%b want 0 0", out_valid, out_partial); end
      vecCount++; if (req_ready !== 2'b00) begin missCount++; $display("[TB] FAIL ar_ready: got %b want 00", req_ready); end
      #1;
      reset_n = 1'b1;
      tick();
      vecCount++; if (out_valid !== 1'b0) begin missCount++; $display("[TB] FAIL ar_no_output: got %b want 0", out_valid); end
      applyStimulus(2'b10, 2'b10, 1'b0, 1'b0);
      vecCount++; if (req_ready !== 2'b10) begin missCount++; $display("[TB] FAIL ar_next_first: got %b want 10", req_ready); end
      tick();
      applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
      vecCount++; if (req_ready !== 2'b01) begin missCount++; $display("[TB] FAIL ar_next_second: got %b want 01", req_ready); end
      tick();
      vecCount++; if (out !== 2'b01 || out_valid !== 1'b1 || out_partial !== 1'b0) begin missCount++; $display("[TB] FAIL ar_next_out: got out=%b valid=%b partial=%b want 01 1 0", out, out_valid, out_partial); end
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
      tick();
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_order0();
      test_order1();
      test_arbitration();
      test_hold();
      test_timeout();
      test_timeout_race();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
